cache_assoc_wb: RTL

//  Parametrised N-way set-associative, write-back, write-allocate cache, successor of the fixed 2-way cache.
//  Tag/valid/dirty, data array, round-robin victim select and miss FSM are in one block.

---
 rtl/cache_assoc_wb_if.sv | 30 +++
 rtl/cache_assoc_wb.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/cache_assoc_wb_if.sv
// CPU SRAM-style port plus the miss/refill/write-back line handshake of the
// set-associative write-back cache; the cache takes the slave side.
interface cache_assoc_wb_if #(
    parameter int CL_WD = 512
);
    logic             sram_en;
    logic [3:0]       sram_wen;
    logic [31:0]      sram_addr;
    logic [31:0]      sram_wdata;
    logic             cached;
    logic             refresh;
    logic [CL_WD-1:0] cacheline_new;
    logic             stallreq;
    logic [31:0]      sram_rdata;
    logic             miss;
    logic [31:0]      raddr;
    logic             write_back;
    logic [31:0]      waddr;
    logic [CL_WD-1:0] cacheline_old;

    modport master (
        output sram_en, sram_wen, sram_addr, sram_wdata, cached, refresh, cacheline_new,
        input  stallreq, sram_rdata, miss, raddr, write_back, waddr, cacheline_old
    );

    modport slave (
        input  sram_en, sram_wen, sram_addr, sram_wdata, cached, refresh, cacheline_new,
        output stallreq, sram_rdata, miss, raddr, write_back, waddr, cacheline_old
    );
endinterface

// File: rtl/cache_assoc_wb.sv
// N-way set-associative write-back / write-allocate cache with round-robin
// victim selection and a two-state miss FSM; plus its lookup checker.
module cache_assoc_wb_chk (
    input logic       clk,
    input logic       rst,
    input logic       lookup,
    input logic [3:0] hit_cnt
);
    a_single_hit: assert property (@(posedge clk) disable iff (!rst) lookup |-> (hit_cnt <= 4'd1));
endmodule

module cache_assoc_wb #(
    parameter int WAYS       = 2,
    parameter int SETS       = 64,
    parameter int LINE_WORDS = 16
) (
    input logic             clk,
    input logic             rst,
    cache_assoc_wb_if.slave bus
);
    localparam int CL_WD   = LINE_WORDS * 32;
    localparam int OFF_WD  = $clog2(LINE_WORDS * 4);
    localparam int IDX_WD  = $clog2(SETS);
    localparam int TAG_WD  = 32 - IDX_WD - OFF_WD;
    localparam int WSEL_WD = OFF_WD - 2;
    localparam int WAY_WD  = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_MISS = 1'b1} state_t;

    state_t              state_r, state_nx;
    logic [TAG_WD-1:0]   tag_r   [WAYS][SETS];
    logic [SETS-1:0]     valid_r [WAYS];
    logic [SETS-1:0]     dirty_r [WAYS];
    logic [WAY_WD-1:0]   vptr_r  [SETS];
    logic [31:0]         data_r  [WAYS][SETS][LINE_WORDS];

    logic [31:0]         rdata_r, raddr_r, waddr_r;
    logic                miss_r, wb_r;
    logic [CL_WD-1:0]    old_r;
    logic [IDX_WD-1:0]   miss_idx_r;
    logic [TAG_WD-1:0]   miss_tag_r;
    logic [WAY_WD-1:0]   victim_r;

    logic [TAG_WD-1:0]   tag_s;
    logic [IDX_WD-1:0]   idx_s;
    logic [WSEL_WD-1:0]  word_s;
    logic [WAY_WD-1:0]   vway_s, hit_way_s;
    logic                hit_s, lookup_s, stall_s, fill_s;
    logic [3:0]          hit_cnt_s;
    logic [31:0]         merged_s;
    logic [CL_WD-1:0]    victim_line_s;
    logic                unused_addr_s;

    assign tag_s         = bus.sram_addr[31 -: TAG_WD];
    assign idx_s         = bus.sram_addr[OFF_WD +: IDX_WD];
    assign word_s        = bus.sram_addr[2 +: WSEL_WD];
    assign unused_addr_s = ^bus.sram_addr[1:0];
    assign vway_s        = vptr_r[idx_s];
    assign lookup_s      = rst && (state_r == ST_IDLE) && bus.sram_en && bus.cached;
    assign fill_s        = (state_r == ST_MISS) && bus.refresh;

    // Tag compare across all ways of the addressed set
    always_comb begin
        hit_s     = 1'b0;
        hit_way_s = '0;
        hit_cnt_s = 4'd0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_r[w][idx_s] && (tag_r[w][idx_s] == tag_s)) begin
                hit_s     = 1'b1;
                hit_way_s = WAY_WD'(w);
                hit_cnt_s = hit_cnt_s + 4'd1;
            end else begin
                hit_s     = hit_s;
            end
        end
    end

    // Byte-enable merge of the write data into the hit word
    always_comb begin
        merged_s = data_r[hit_way_s][idx_s][word_s];
        for (int b = 0; b < 4; b++) begin
            if (bus.sram_wen[b]) begin
                merged_s[8*b +: 8] = bus.sram_wdata[8*b +: 8];
            end else begin
                merged_s[8*b +: 8] = merged_s[8*b +: 8];
            end
        end
    end

    // Victim line gathered for the write-back path
    always_comb begin
        victim_line_s = '0;
        for (int i = 0; i < LINE_WORDS; i++) begin
            victim_line_s[32*i +: 32] = data_r[vway_s][idx_s][i];
        end
    end

    // Next-state and stall decode
    always_comb begin
        state_nx = state_r;
        stall_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (lookup_s && !hit_s) begin
                    state_nx = ST_MISS;
                    stall_s  = 1'b1;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_MISS: begin
                stall_s = 1'b1;
                if (bus.refresh) begin
                    state_nx = ST_IDLE;
                end else begin
                    state_nx = ST_MISS;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // State, metadata and handshake registers; reset abandons any miss
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            rdata_r    <= 32'd0;
            miss_r     <= 1'b0;
            wb_r       <= 1'b0;
            raddr_r    <= 32'd0;
            waddr_r    <= 32'd0;
            old_r      <= '0;
            miss_idx_r <= '0;
            miss_tag_r <= '0;
            victim_r   <= '0;
            for (int w = 0; w < WAYS; w++) begin
                valid_r[w] <= '0;
                dirty_r[w] <= '0;
            end
            for (int s = 0; s < SETS; s++) begin
                vptr_r[s] <= '0;
            end
        end else begin
            state_r <= state_nx;
            if (lookup_s && hit_s) begin
                if (bus.sram_wen == 4'd0) begin
                    rdata_r <= data_r[hit_way_s][idx_s][word_s];
                end else begin
                    dirty_r[hit_way_s][idx_s] <= 1'b1;
                end
            end else if (lookup_s) begin
                miss_r     <= 1'b1;
                raddr_r    <= {tag_s, idx_s, {OFF_WD{1'b0}}};
                wb_r       <= valid_r[vway_s][idx_s] && dirty_r[vway_s][idx_s];
                waddr_r    <= {tag_r[vway_s][idx_s], idx_s, {OFF_WD{1'b0}}};
                old_r      <= victim_line_s;
                miss_idx_r <= idx_s;
                miss_tag_r <= tag_s;
                victim_r   <= vway_s;
            end else if (fill_s) begin
                miss_r  <= 1'b0;
                wb_r    <= 1'b0;
                raddr_r <= 32'd0;
                waddr_r <= 32'd0;
                old_r   <= '0;
                valid_r[victim_r][miss_idx_r] <= 1'b1;
                dirty_r[victim_r][miss_idx_r] <= 1'b0;
                vptr_r[miss_idx_r] <= (victim_r == WAY_WD'(WAYS - 1)) ? '0 : victim_r + WAY_WD'(1);
            end
        end
    end

    // Tag and data arrays carry no reset; valid bits qualify them
    always_ff @(posedge clk) begin
        if (lookup_s && hit_s && (bus.sram_wen != 4'd0)) begin
            data_r[hit_way_s][idx_s][word_s] <= merged_s;
        end else if (fill_s) begin
            tag_r[victim_r][miss_idx_r] <= miss_tag_r;
            for (int i = 0; i < LINE_WORDS; i++) begin
                data_r[victim_r][miss_idx_r][i] <= bus.cacheline_new[32*i +: 32];
            end
        end
    end

    assign bus.stallreq      = stall_s && rst;
    assign bus.sram_rdata    = rdata_r;
    assign bus.miss          = miss_r;
    assign bus.raddr         = raddr_r;
    assign bus.write_back    = wb_r;
    assign bus.waddr         = waddr_r;
    assign bus.cacheline_old = old_r;

    cache_assoc_wb_chk u_chk (
        .clk     (clk),
        .rst     (rst),
        .lookup  (lookup_s),
        .hit_cnt (hit_cnt_s)
    );
endmodule
